// File: rtl/psum_stage.sv
// Partial-sum output stage: per-column input capture, per-column FIFOs, a lock-step pop
// across all columns, per-column accumulation (optionally split into two signed half-width
// lanes), optional ReLU, and a registered result.
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_data_i    column c at [psum_bw*(c+1)-1 : psum_bw*c]
//   in_valid_i   per-column write strobe (captured one cycle before the FIFO write)
//   simd_i       1 = two independent signed psum_bw/2 lanes per column
//   acc_en_i     1 = add popped head into the column accumulator
//   acc_clr_i    1 = accumulators read as zero this cycle
//   relu_en_i    1 = clamp negative lanes of the result to zero
//   out_rd_i     pop request (ignored while out_valid_o is low)
//   out_valid_o  every column FIFO holds at least one entry
//   res_data_o   registered result
//   res_valid_o  one-cycle pulse marking new res_data_o
//   full_o       at least one column FIFO is full
//   ready_o      NOT full_o
//   ovf_o        sticky per-column dropped-write flag
module psum_stage #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [psum_bw*col-1:0] in_data_i,
  input  logic [col-1:0]         in_valid_i,
  input  logic                   simd_i,
  input  logic                   acc_en_i,
  input  logic                   acc_clr_i,
  input  logic                   relu_en_i,
  input  logic                   out_rd_i,
  output logic                   out_valid_o,
  output logic [psum_bw*col-1:0] res_data_o,
  output logic                   res_valid_o,
  output logic                   full_o,
  output logic                   ready_o,
  output logic [col-1:0]         ovf_o
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned HW = psum_bw / 2;
  localparam logic [AW:0] FullCnt = (AW + 1)'(depth);

  // Two's-complement add; when split, the halves wrap independently (no carry between lanes).
  function automatic logic [psum_bw-1:0] lane_add(input logic [psum_bw-1:0] a,
                                                  input logic [psum_bw-1:0] b,
                                                  input logic               split);
    logic [psum_bw-1:0] full_sum;
    logic [HW-1:0]      lo_sum;
    logic [HW-1:0]      hi_sum;
    full_sum = a + b;
    lo_sum   = a[HW-1:0] + b[HW-1:0];
    hi_sum   = a[psum_bw-1:HW] + b[psum_bw-1:HW];
    return split ? {hi_sum, lo_sum} : full_sum;
  endfunction

  function automatic logic [psum_bw-1:0] relu(input logic [psum_bw-1:0] v,
                                              input logic               split);
    logic [psum_bw-1:0] r;
    r = v;
    if (split) begin
      if (v[psum_bw-1]) r[psum_bw-1:HW] = '0;
      if (v[HW-1])      r[HW-1:0]       = '0;
    end else if (v[psum_bw-1]) begin
      r = '0;
    end
    return r;
  endfunction

  // Input capture
  logic [psum_bw*col-1:0] in_data_q;
  logic [col-1:0]         in_valid_q;

  // FIFO state
  logic [psum_bw-1:0]        mem_q [col][depth];
  logic [col-1:0][AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [col-1:0][AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [col-1:0][AW:0]      cnt_q, cnt_d;
  logic [col-1:0]            ovf_q, ovf_d;

  // Datapath state
  logic [col-1:0][psum_bw-1:0] acc_q, acc_d;
  logic [psum_bw*col-1:0]      res_data_q, res_data_d;
  logic                        res_valid_q;

  // Decode
  logic [col-1:0]              col_full;
  logic [col-1:0]              col_empty;
  logic [col-1:0]              wr_en;
  logic                        pop;
  logic [col-1:0][psum_bw-1:0] head;
  logic [col-1:0][psum_bw-1:0] acc_opnd;
  logic [col-1:0][psum_bw-1:0] sum_s;

  // Flags come only from registered occupancy, never from in_valid_i or out_rd_i.
  always_comb begin
    for (int unsigned c = 0; c < col; c++) begin
      col_full[c]  = (cnt_q[c] == FullCnt);
      col_empty[c] = (cnt_q[c] == '0);
    end
  end

  assign out_valid_o = ~|col_empty;
  assign full_o      = |col_full;
  assign ready_o     = ~full_o;
  assign pop         = out_rd_i & out_valid_o;

  always_comb begin
    res_data_d = res_data_q;
    for (int unsigned c = 0; c < col; c++) begin
      // Fullness is judged before the pop, so a write to a full column drops even on a pop.
      wr_en[c]    = in_valid_q[c] & ~col_full[c];
      ovf_d[c]    = ovf_q[c] | (in_valid_q[c] & col_full[c]);
      wr_ptr_d[c] = wr_ptr_q[c] + AW'(wr_en[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + AW'(pop);

      unique case ({wr_en[c], pop})
        2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
        2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
        default: cnt_d[c] = cnt_q[c];
      endcase

      head[c]     = mem_q[c][rd_ptr_q[c]];
      acc_opnd[c] = acc_clr_i ? '0 : acc_q[c];
      sum_s[c]    = acc_en_i ? lane_add(head[c], acc_opnd[c], simd_i) : head[c];

      // Accumulator keeps the pre-ReLU sum.
      acc_d[c] = acc_q[c];
      if (pop && acc_en_i) begin
        acc_d[c] = sum_s[c];
      end else if (!pop && acc_clr_i) begin
        acc_d[c] = '0;
      end

      if (pop) begin
        res_data_d[c*psum_bw +: psum_bw] = relu_en_i ? relu(sum_s[c], simd_i) : sum_s[c];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_data_q   <= '0;
      in_valid_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      in_data_q   <= in_data_i;
      in_valid_q  <= in_valid_i;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_valid_q <= pop;
    end
  end

  // Storage needs no reset: pointers and occupancy decide what is valid.
  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < col; c++) begin
      if (wr_en[c]) begin
        mem_q[c][wr_ptr_q[c]] <= in_data_q[c*psum_bw +: psum_bw];
      end
    end
  end

  assign res_data_o  = res_data_q;
  assign res_valid_o = res_valid_q;
  assign ovf_o       = ovf_q;

endmodule

// File: doc/psum_stage.md
PSUM_STAGE -- requirements
Module: psum_stage

Interface
REQ-001 Parameter col, default 8: number of independent columns.
REQ-002 Parameter psum_bw, default 16: partial-sum width per column; SHALL be even.
REQ-003 Parameter depth, default 16: entries per column FIFO; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low (0 = reset), applied immediately, released synchronously to clk.
REQ-006 in_data  input  psum_bw*col  column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-007 in_valid  input  col  per-column write strobe.
REQ-008 simd  input  1  1 = each column holds two independent signed psum_bw/2 lanes.
REQ-009 acc_en  input  1  1 = add the popped entry into the per-column accumulator.
REQ-010 acc_clr  input  1  1 = treat the accumulators as zero for this cycle.
REQ-011 relu_en  input  1  1 = clamp negative results to zero on output.
REQ-012 out_rd  input  1  pop request.
REQ-013 out_valid  output  1  every column FIFO is non-empty.
REQ-014 res_data  output  psum_bw*col  registered result.
REQ-015 res_valid  output  1  one-cycle pulse marking new res_data.
REQ-016 full  output  1  at least one column FIFO is full.
REQ-017 ready  output  1  equals NOT full.
REQ-018 ovf  output  col  sticky per-column overflow flag.

Function
REQ-019 Input capture: in_data and in_valid SHALL be registered once before the FIFO write, so a write takes effect 1 cycle after the strobe.
REQ-020 Each column SHALL write its registered data when its registered valid is 1 and its FIFO is not full. Columns write independently, in per-column FIFO order.
REQ-021 A write to a full column SHALL be dropped and SHALL set ovf[c] to 1. ovf[c] SHALL clear only on reset.
REQ-022 out_valid SHALL be 1 only when all col FIFOs hold at least 1 entry.
REQ-023 A pop SHALL occur when out_rd=1 and out_valid=1. It removes the head of every column in the same cycle. When out_valid=0, out_rd SHALL be ignored.
REQ-024 Simultaneous write and pop on the same column SHALL both take effect, and the occupancy SHALL stay unchanged. When a column is full, its pending write is still dropped, because fullness is judged before the pop.
REQ-025 Read and write pointers SHALL wrap modulo depth. Occupancy SHALL be tracked with log2(depth)+1 bits so that full and empty are distinguishable.
REQ-026 Per column on a pop:
- A = 0 if acc_clr=1, else acc[c].
- S = head[c] + A if acc_en=1, else head[c].
REQ-027 acc[c] SHALL load S on a pop when acc_en=1. When acc_clr=1 without a pop, acc[c] SHALL load 0. Otherwise acc[c] SHALL hold.
REQ-028 Addition SHALL be two's-complement and wrap modulo 2^psum_bw. When simd=1, each psum_bw/2 half SHALL wrap independently, with no carry between halves.
REQ-029 ReLU SHALL apply per lane: the full column when simd=0, each half when simd=1. A negative lane becomes 0. The accumulator SHALL store the pre-ReLU value S.
REQ-030 res_data SHALL update 1 cycle after a pop, and res_valid SHALL pulse 1 in that same cycle. Otherwise res_data SHALL hold and res_valid SHALL be 0.
REQ-031 simd, acc_en, acc_clr and relu_en SHALL be sampled in the pop cycle only.
REQ-032 full and out_valid SHALL be decoded from the registered occupancy, with no combinational path from in_valid or out_rd.

Reset
REQ-033 With reset=0, the following SHALL clear asynchronously:
- all pointers, occupancies and accumulators;
- the input capture registers;
- res_data = 0 and res_valid = 0;
- ovf = 0, out_valid = 0, full = 0, ready = 1.
REQ-034 Reset mid-operation SHALL discard all stored entries and any in-flight captured write. After release, the first write SHALL land in slot 0.

Verification
REQ-035 col=2, psum_bw=16. Write 5 to column 0 and 7 to column 1 in the same cycle; out_valid rises 2 cycles after the strobe. Pop with acc_en=0 -> res_data={7,5} with res_valid pulse 1 cycle later.
REQ-036 acc_en=1. Pop heads 100, then 0xFFFF (-1), then acc_clr=1 with head 3 -> results 100, 99, 3. Wrap check: acc 0x7FFF plus head 1 -> 0x8000.
REQ-037 simd=1, relu_en=1. Head 0x80FF (lanes -128, -1) plus acc 0x0102 (lanes 1, 2) -> S=0x8101, res_data=0x0001. Accumulator = 0x8101, with no carry out of the low lane.
REQ-038 depth=4. Write 5 entries to column 0 only -> full=1 and ready=0 after 4 entries, the 5th is dropped, ovf[0]=1, and out_valid stays 0 until column 1 is written.
REQ-039 Hold a column at 3 of 4 entries, then strobe a write and pop together every cycle for 10 cycles -> occupancy constant, data returned in FIFO order across pointer wrap, and ovf stays 0.
REQ-040 Assert reset=0 asynchronously between clock edges with 3 entries stored -> outputs take their reset values immediately. After release, out_valid=0 until new writes arrive.
